// File: rtl/overlay_box_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : overlay_box_gen_if
// Description : Host register bus for overlay_box_gen. A write is held on
//               reg_wr (with addr/data stable) until reg_ack pulses.
// Revision    : 1.0  initial release
// ============================================================================
interface overlay_box_gen_if;
  logic        reg_wr;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_ack;

  // Host side drives requests, sees the acknowledge
  modport master (output reg_wr, output reg_addr, output reg_wdata, input reg_ack);
  // Overlay generator side
  modport slave  (input reg_wr, input reg_addr, input reg_wdata, output reg_ack);
endinterface
`default_nettype wire

// File: rtl/overlay_box_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : overlay_box_gen
// Description : Foreground source for the PAL 576i mixer. Draws a single
//               filled or outline rectangle in one colour; 18'b0 output means
//               transparent. Geometry/colour written into shadow registers are
//               copied to the active set on each vsync_n falling edge.
//               Optional macro OVERLAY_BLINK_EN adds a 32-on/32-off field blink.
// Revision    : 1.0  initial release
// ============================================================================
module overlay_box_gen #(
  parameter int H_START  = 132,
  parameter int V_START  = 23,
  parameter int H_ACTIVE = 720,
  parameter int V_ACTIVE = 288
) (
  input  logic                pixelClockX6,
  input  logic                nReset,
  input  logic [2:0]          pixelClockPhase,
  input  logic                hsync_n,
  input  logic                vsync_n,
  overlay_box_gen_if.slave    reg_bus,
  output logic [17:0]         rgb_fg
);

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);

  logic        hsync_hist_q, vsync_hist_q;
  logic        w_hfall, w_vfall, w_pix_strobe;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        ack_q;

  logic [10:0] sh_x0_q, sh_x1_q, act_x0_q, act_x1_q;
  logic [9:0]  sh_y0_q, sh_y1_q, act_y0_q, act_y1_q;
  logic [17:0] sh_col_q, act_col_q;
  logic        sh_en_q, sh_out_q, act_en_q, act_out_q;

  logic [10:0] w_x;
  logic [9:0]  w_y;
  logic        w_win, w_inside, w_edge, w_draw, w_blink_ok;
  logic [17:0] w_col, rgb_d, rgb_q;

  assign w_hfall      = hsync_hist_q & ~hsync_n;
  assign w_vfall      = vsync_hist_q & ~vsync_n;
  assign w_pix_strobe = (pixelClockPhase == 3'd0);

  // Sync history for edge detection, valid in any phase
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      hsync_hist_q <= 1'b1;
      vsync_hist_q <= 1'b1;
    end else begin
      hsync_hist_q <= hsync_n;
      vsync_hist_q <= vsync_n;
    end
  end

  // Next-state of the raster counters; vsync clear beats the hsync increment
  always_comb begin
    hcnt_d = hcnt_q;
    if (w_hfall)
      hcnt_d = '0;
    else if (w_pix_strobe && (hcnt_q != 11'h7FF))
      hcnt_d = hcnt_q + 11'd1;

    vcnt_d = vcnt_q;
    if (w_vfall)
      vcnt_d = '0;
    else if (w_hfall && (vcnt_q != 10'h3FF))
      vcnt_d = vcnt_q + 10'd1;
  end

  // Raster counter registers
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Acknowledge one cycle after a request is first seen; ack never repeats back-to-back
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) ack_q <= 1'b0;
    else         ack_q <= reg_bus.reg_wr & ~ack_q;
  end

  assign reg_bus.reg_ack = ack_q;

  // Shadow registers capture at the end of the ack cycle, so a write acked on
  // the vsync cycle misses that field's transfer and waits for the next one
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      sh_x0_q  <= '0;
      sh_y0_q  <= '0;
      sh_x1_q  <= '0;
      sh_y1_q  <= '0;
      sh_col_q <= '0;
      sh_en_q  <= 1'b0;
      sh_out_q <= 1'b0;
    end else if (ack_q) begin
      case (reg_bus.reg_addr)
        3'd0: sh_x0_q <= reg_bus.reg_wdata[10:0];
        3'd1: sh_y0_q <= reg_bus.reg_wdata[9:0];
        3'd2: sh_x1_q <= reg_bus.reg_wdata[10:0];
        3'd3: sh_y1_q <= reg_bus.reg_wdata[9:0];
        3'd4: sh_col_q[15:0] <= reg_bus.reg_wdata;
        3'd5: begin
          sh_col_q[17:16] <= reg_bus.reg_wdata[1:0];
          sh_en_q         <= reg_bus.reg_wdata[8];
          sh_out_q        <= reg_bus.reg_wdata[9];
        end
        default: ;
      endcase
    end
  end

  // Coherent per-field copy of the shadow set
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      act_x0_q  <= '0;
      act_y0_q  <= '0;
      act_x1_q  <= '0;
      act_y1_q  <= '0;
      act_col_q <= '0;
      act_en_q  <= 1'b0;
      act_out_q <= 1'b0;
    end else if (w_vfall) begin
      act_x0_q  <= sh_x0_q;
      act_y0_q  <= sh_y0_q;
      act_x1_q  <= sh_x1_q;
      act_y1_q  <= sh_y1_q;
      act_col_q <= sh_col_q;
      act_en_q  <= sh_en_q;
      act_out_q <= sh_out_q;
    end
  end

`ifdef OVERLAY_BLINK_EN
  logic       sh_blink_q, act_blink_q;
  logic [5:0] fcnt_q;

  // Blink enable bit and a free-running field counter (wraps after 63)
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      sh_blink_q  <= 1'b0;
      act_blink_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      if (ack_q && (reg_bus.reg_addr == 3'd5))
        sh_blink_q <= reg_bus.reg_wdata[10];
      if (w_vfall) begin
        act_blink_q <= sh_blink_q;
        fcnt_q      <= fcnt_q + 6'd1;
      end
    end
  end

  assign w_blink_ok = ~(act_blink_q & fcnt_q[5]);
`else
  assign w_blink_ok = 1'b1;
`endif

  assign w_x = hcnt_q - H_LO;
  assign w_y = vcnt_q - V_LO;

  // Pixel decision; an inverted box (X0>X1 or Y0>Y1) fails the inside test
  always_comb begin
    w_win    = (hcnt_q >= H_LO) && (hcnt_q < H_HI) && (vcnt_q >= V_LO) && (vcnt_q < V_HI);
    w_inside = (w_x >= act_x0_q) && (w_x <= act_x1_q) &&
               (w_y >= act_y0_q) && (w_y <= act_y1_q);
    w_edge   = (w_x == act_x0_q) || (w_x == act_x1_q) ||
               (w_y == act_y0_q) || (w_y == act_y1_q);
    w_draw   = act_en_q && w_win && w_inside && (!act_out_q || w_edge) && w_blink_ok;
    w_col    = (act_col_q == 18'd0) ? 18'h00001 : act_col_q;
    rgb_d    = w_draw ? w_col : 18'd0;
  end

  // Output updates only on pixel strobes and holds for the other phases
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset)           rgb_q <= '0;
    else if (w_pix_strobe) rgb_q <= rgb_d;
  end

  assign rgb_fg = rgb_q;

endmodule
`default_nettype wire
